// File: rtl/layer_generator.sv
// rtl/layer_generator.sv - pseudo-random block-layer producer, every layer reachable from the previous one
// Layer vectors are [6:0] with bit 6 = position 0 (leftmost).
module layer_generator #(
   parameter int unsigned NUM_LAYERS = 5,
   parameter int unsigned LOAD_GAP   = 4,
   parameter int unsigned MAX_TRIES  = 15,
   parameter int unsigned MIN_BLOCKS = 2,
   parameter logic [15:0] SEED       = 16'hACE1,
   parameter logic [6:0]  START_MAP  = 7'b0001000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       module_en,
   input  logic       jump_left,
   input  logic       jump_right,
   output logic [6:0] layer_map_out,
   output logic [6:0] block_type_out,
   output logic [6:0] bonus_map_out,
   output logic       load_layer,
   output logic       layer_ready
);

   localparam int TW = $clog2(MAX_TRIES + 2);
   localparam int FW = $clog2(NUM_LAYERS + 2);
   localparam int GW = $clog2(LOAD_GAP + 2);

   typedef enum logic [2:0] {IDLE, FILL_GEN, FILL_GAP, READY, GEN} state_e;

   state_e        state_q, state_d;
   logic [15:0]   lfsr_q, lfsr_d;
   logic [6:0]    map_q, map_d;
   logic [6:0]    type_q, type_d;
   logic [6:0]    bonus_q, bonus_d;
   logic [6:0]    prev_q, prev_d;
   logic          load_q, load_d;
   logic [TW-1:0] tries_q, tries_d;
   logic [FW-1:0] fill_q, fill_d;
   logic [GW-1:0] gap_q, gap_d;

   logic [6:0]    cand_map, cand_type, cand_bonus, reach;
   int unsigned   cand_cnt;
   logic          cand_ok, fallback, accept;

   function automatic int unsigned popcount7(input logic [6:0] v);
      int unsigned n;
      n = 0;
      for (int i = 0; i < 7; i++)
         if (v[i]) n++;
      return n;
   endfunction

   always_comb begin
      cand_map  = lfsr_q[6:0];
      cand_type = lfsr_q[13:7] & cand_map;
      reach     = prev_q | (prev_q << 1) | (prev_q >> 1);
      cand_cnt  = popcount7(cand_map);
      cand_ok   = (cand_cnt >= MIN_BLOCKS) && (cand_cnt <= 6) &&
                  (|cand_type) && (|(cand_type & reach));
      cand_bonus = '0;
      // ascending scan: the highest (leftmost) solid bit is the last one written
      if (lfsr_q[15:14] == 2'b11) begin
         for (int i = 0; i < 7; i++)
            if (cand_type[i]) cand_bonus = 7'(1) << i;
      end
      fallback = (tries_q == TW'(MAX_TRIES));
      accept   = cand_ok || fallback;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         lfsr_q  <= SEED;
         map_q   <= '0;
         type_q  <= '0;
         bonus_q <= '0;
         prev_q  <= START_MAP;
         load_q  <= 1'b0;
         tries_q <= '0;
         fill_q  <= '0;
         gap_q   <= '0;
      end else begin
         state_q <= state_d;
         lfsr_q  <= lfsr_d;
         map_q   <= map_d;
         type_q  <= type_d;
         bonus_q <= bonus_d;
         prev_q  <= prev_d;
         load_q  <= load_d;
         tries_q <= tries_d;
         fill_q  <= fill_d;
         gap_q   <= gap_d;
      end
   end

   always_comb begin
      state_d = state_q;
      lfsr_d  = lfsr_q;
      map_d   = map_q;
      type_d  = type_q;
      bonus_d = bonus_q;
      prev_d  = prev_q;
      load_d  = 1'b0;
      tries_d = tries_q;
      fill_d  = fill_q;
      gap_d   = gap_q;
      case (state_q)
         IDLE: begin
            map_d   = '0;
            type_d  = '0;
            bonus_d = '0;
            prev_d  = START_MAP;
            tries_d = '0;
            fill_d  = '0;
            gap_d   = '0;
            if (module_en) state_d = FILL_GEN;
         end
         FILL_GEN, GEN: begin
            lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
            if (accept) begin
               map_d   = fallback ? prev_q : cand_map;
               type_d  = fallback ? prev_q : cand_type;
               bonus_d = fallback ? 7'd0 : cand_bonus;
               prev_d  = fallback ? prev_q : cand_type;
               tries_d = '0;
               if (state_q == FILL_GEN) begin
                  fill_d  = fill_q + FW'(1);
                  load_d  = (fill_q != FW'(NUM_LAYERS));
                  gap_d   = '0;
                  state_d = FILL_GAP;
               end else begin
                  state_d = READY;
               end
            end else begin
               tries_d = tries_q + TW'(1);
            end
         end
         FILL_GAP: begin
            gap_d = gap_q + GW'(1);
            // the layer after the last loaded one is produced in GEN so it is never pulsed
            if (gap_q == GW'(LOAD_GAP - 1)) begin
               gap_d   = '0;
               state_d = (fill_q < FW'(NUM_LAYERS)) ? FILL_GEN : GEN;
            end
         end
         READY: begin
            if (jump_left || jump_right) state_d = GEN;
         end
         default: state_d = IDLE;
      endcase
      if (!module_en) begin
         state_d = IDLE;
         lfsr_d  = lfsr_q;
         map_d   = '0;
         type_d  = '0;
         bonus_d = '0;
         prev_d  = START_MAP;
         load_d  = 1'b0;
         tries_d = '0;
         fill_d  = '0;
         gap_d   = '0;
      end
   end

   always_comb begin
      layer_ready = (state_q == READY);
   end

   assign layer_map_out  = map_q;
   assign block_type_out = type_q;
   assign bonus_map_out  = bonus_q;
   assign load_layer     = load_q;

endmodule
